// File: rtl/mel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mel_pkg
//  Description : Shared constants and FSM state type for the mel log stage.
//                The mel filterbank uses the same NUM_CH and IN_W.
//  Revision    : 1.0 - initial release
// ============================================================================
package mel_pkg;

   localparam int NUM_CH = 10;              // mel channels per frame
   localparam int IN_W   = 47;              // width of one mel energy
   localparam int INT_W  = 6;               // integer bits of log2 result
   localparam int FRAC_W = 10;              // fractional bits of log2 result
   localparam int OUT_W  = INT_W + FRAC_W;  // result width
   localparam int CH_W   = 4;               // channel index width
   localparam int NUM_W  = 5;               // frame number width

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage : mel_pkg
`default_nettype wire

// File: rtl/mel_lod.sv
`default_nettype none
// ============================================================================
//  Module      : mel_lod
//  Description : Combinational leading-one detect and normalise of one mel
//                energy. o_e is the MSB index, o_mant the FRAC_W bits just
//                below the leading one (zero padded for small values).
//  Revision    : 1.0 - initial release
// ============================================================================
module mel_lod
   import mel_pkg::*;
(
   input  logic [IN_W-1:0]   i_x,
   output logic [INT_W-1:0]  o_e,
   output logic [FRAC_W-1:0] o_mant,
   output logic              o_zero
);

   // The leading one itself is implicit, so it is dropped; FRAC_W zeros are
   // appended so a leading one near bit 0 still yields a full-width slice.
   logic [IN_W+FRAC_W-2:0] w_ext;
   logic [INT_W-1:0]       w_e;
   logic [FRAC_W-1:0]      w_mant;

   assign w_ext = {i_x[IN_W-2:0], {FRAC_W{1'b0}}};

   // Priority scan from LSB upward: the highest set bit wins.
   always_comb begin
      w_e    = '0;
      w_mant = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (i_x[i]) begin
            w_e    = INT_W'(i);
            w_mant = w_ext[i +: FRAC_W];
         end
      end
   end

   assign o_e    = w_e;
   assign o_mant = w_mant;
   assign o_zero = (i_x == '0);

endmodule : mel_lod
`default_nettype wire

// File: rtl/mel_log.sv
`default_nettype none
// ============================================================================
//  Module      : mel_log
//  Description : Captures one frame of NUM_CH mel energies and streams their
//                Mitchell log2 approximations out one channel per cycle
//                through a 2-stage pipeline, with channel/frame/last/zero
//                sidebands, busy and sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module mel_log
   import mel_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_CH*IN_W-1:0] in,
   input  logic                   in_valid,
   input  logic [NUM_W-1:0]       in_num,
   output logic [OUT_W-1:0]       out_log,
   output logic                   out_valid,
   output logic [CH_W-1:0]        out_ch,
   output logic [NUM_W-1:0]       out_frame,
   output logic                   out_last,
   output logic                   out_zero,
   output logic                   busy,
   output logic                   overflow
);

   state_t            r_state;
   logic [IN_W-1:0]   r_buf [NUM_CH];
   logic [NUM_W-1:0]  r_frame;
   logic [CH_W-1:0]   r_cnt;
   logic              r_busy;
   logic              r_ovf;

   logic              r_s1_valid;
   logic [INT_W-1:0]  r_s1_e;
   logic [FRAC_W-1:0] r_s1_mant;
   logic              r_s1_zero;
   logic [CH_W-1:0]   r_s1_ch;
   logic [NUM_W-1:0]  r_s1_frame;
   logic              r_s1_last;

   logic [IN_W-1:0]   w_x;
   logic [INT_W-1:0]  w_e;
   logic [FRAC_W-1:0] w_mant;
   logic              w_zero;

   // r_cnt never leaves 0..NUM_CH-1, so the read stays inside the buffer.
   assign w_x = r_buf[r_cnt];

   mel_lod u_lod (
      .i_x    (w_x),
      .o_e    (w_e),
      .o_mant (w_mant),
      .o_zero (w_zero)
   );

   // Frame capture, channel sequencing, busy and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_frame <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            r_buf[k] <= '0;
         end
      end else begin
         // Any pulse arriving while a frame is in flight is dropped.
         if (in_valid && (r_state != IDLE)) begin
            r_ovf <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     r_buf[k] <= in[k*IN_W +: IN_W];
                  end
                  r_frame <= in_num;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (r_cnt == LAST_CH) begin
                  r_state <= DRAIN;
               end else begin
                  r_cnt <= r_cnt + CH_W'(1);
               end
            end
            DRAIN: begin
               // Drops together with out_last so the next pulse is taken
               // one cycle after the final channel.
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Stage 1: register the leading-one detect result of the selected channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_e     <= '0;
         r_s1_mant  <= '0;
         r_s1_zero  <= 1'b0;
         r_s1_ch    <= '0;
         r_s1_frame <= '0;
         r_s1_last  <= 1'b0;
      end else if (r_state == RUN) begin
         r_s1_valid <= 1'b1;
         r_s1_e     <= w_e;
         r_s1_mant  <= w_mant;
         r_s1_zero  <= w_zero;
         r_s1_ch    <= r_cnt;
         r_s1_frame <= r_frame;
         r_s1_last  <= (r_cnt == LAST_CH);
      end else begin
         r_s1_valid <= 1'b0;
         r_s1_e     <= '0;
         r_s1_mant  <= '0;
         r_s1_zero  <= 1'b0;
         r_s1_ch    <= '0;
         r_s1_frame <= '0;
         r_s1_last  <= 1'b0;
      end
   end

   // Stage 2: assemble the fixed-point log and present it with sidebands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_log   <= '0;
         out_ch    <= '0;
         out_frame <= '0;
         out_last  <= 1'b0;
         out_zero  <= 1'b0;
      end else begin
         out_valid <= r_s1_valid;
         out_log   <= (r_s1_valid && !r_s1_zero) ? {r_s1_e, r_s1_mant} : '0;
         out_ch    <= r_s1_ch;
         out_frame <= r_s1_frame;
         out_last  <= r_s1_last;
         out_zero  <= r_s1_zero;
      end
   end

   assign busy     = r_busy;
   assign overflow = r_ovf;

endmodule : mel_log
`default_nettype wire

// File: tb/tb_mel_log.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mel_log
//  Description : Self-checking bench for mel_log. A cycle-indexed reference
//                model predicts, per accepted frame, the output of every
//                channel from floor(log2 x) and its linear mantissa, plus
//                busy and sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mel_log;
   import mel_pkg::*;

   typedef struct {
      logic [OUT_W-1:0] lg;
      logic [CH_W-1:0]  ch;
      logic [NUM_W-1:0] fr;
      logic             last;
      logic             zero;
   } exp_t;

   logic                   clk;
   logic                   rst_n;
   logic [NUM_CH*IN_W-1:0] tb_in;
   logic                   tb_in_valid;
   logic [NUM_W-1:0]       tb_in_num;
   logic [OUT_W-1:0]       w_out_log;
   logic                   w_out_valid;
   logic [CH_W-1:0]        w_out_ch;
   logic [NUM_W-1:0]       w_out_frame;
   logic                   w_out_last;
   logic                   w_out_zero;
   logic                   w_busy;
   logic                   w_overflow;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // Reference model state
   exp_t m_exp [int];
   int   m_free   = 0;   // first edge index at which a new pulse is accepted
   bit   m_ovf    = 1'b0;
   int   m_frames = 0;

   mel_log dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (tb_in),
      .in_valid  (tb_in_valid),
      .in_num    (tb_in_num),
      .out_log   (w_out_log),
      .out_valid (w_out_valid),
      .out_ch    (w_out_ch),
      .out_frame (w_out_frame),
      .out_last  (w_out_last),
      .out_zero  (w_out_zero),
      .busy      (w_busy),
      .overflow  (w_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // floor(log2 x) * 2^FRAC_W + floor((x - 2^e) * 2^FRAC_W / 2^e)
   function automatic logic [OUT_W-1:0] ref_log(input logic [63:0] x);
      logic [63:0] t;
      logic [63:0] m;
      int          e;
      if (x == 64'd0) return '0;
      t = x;
      e = 0;
      while (t > 64'd1) begin
         t = t >> 1;
         e++;
      end
      m = ((x - (64'd1 << e)) << FRAC_W) >> e;
      return OUT_W'(e * (1 << FRAC_W) + int'(m));
   endfunction

   function automatic logic [IN_W-1:0] rand_energy();
      logic [63:0] r;
      r = {$urandom, $urandom};
      r = r >> $urandom_range(17, 64);
      return IN_W'(r);
   endfunction

   function automatic logic [NUM_CH*IN_W-1:0] rand_frame();
      logic [NUM_CH*IN_W-1:0] d;
      for (int k = 0; k < NUM_CH; k++) d[k*IN_W +: IN_W] = rand_energy();
      return d;
   endfunction

   task automatic check_outputs();
      chk("busy", 64'(w_busy), 64'((cyc + 2) <= m_free));
      chk("overflow", 64'(w_overflow), 64'(m_ovf));
      chk("valid", 64'(w_out_valid), 64'(m_exp.exists(cyc)));
      if (m_exp.exists(cyc)) begin
         chk("log",   64'(w_out_log),   64'(m_exp[cyc].lg));
         chk("ch",    64'(w_out_ch),    64'(m_exp[cyc].ch));
         chk("frame", 64'(w_out_frame), 64'(m_exp[cyc].fr));
         chk("last",  64'(w_out_last),  64'(m_exp[cyc].last));
         chk("zero",  64'(w_out_zero),  64'(m_exp[cyc].zero));
         m_exp.delete(cyc);
      end
   endtask

   // Apply one cycle of inputs, advance the model over the edge, then check.
   task automatic step(input bit v, input logic [NUM_CH*IN_W-1:0] d, input logic [NUM_W-1:0] num);
      logic [IN_W-1:0] x;
      exp_t            e;
      tb_in       = d;
      tb_in_valid = v;
      tb_in_num   = num;
      @(posedge clk);
      cyc++;
      if (v) begin
         if (cyc >= m_free) begin
            for (int k = 0; k < NUM_CH; k++) begin
               x      = d[k*IN_W +: IN_W];
               e.lg   = ref_log(64'(x));
               e.ch   = CH_W'(k);
               e.fr   = num;
               e.last = (k == NUM_CH - 1);
               e.zero = (x == '0);
               m_exp[cyc + 2 + k] = e;
            end
            m_free = cyc + NUM_CH + 2;
            m_frames++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0);
   endtask

   // Assert reset mid-cycle, confirm outputs clear at once, release later.
   task automatic do_reset();
      tb_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(w_out_valid), 64'd0);
      chk("rst_log",   64'(w_out_log),   64'd0);
      chk("rst_busy",  64'(w_busy),      64'd0);
      chk("rst_ovf",   64'(w_overflow),  64'd0);
      m_exp.delete();
      m_free = 0;
      m_ovf  = 1'b0;
      repeat (2) begin
         @(posedge clk);
         cyc++;
      end
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NUM_CH*IN_W-1:0] d;
      int                     guard;

      rst_n       = 1'b0;
      tb_in       = '0;
      tb_in_valid = 1'b0;
      tb_in_num   = '0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check_outputs();

      // All channels equal 1, frame number 3
      for (int k = 0; k < NUM_CH; k++) d[k*IN_W +: IN_W] = IN_W'(1);
      step(1'b1, d, 5'd3);
      idle(14);

      // Boundary energies on channels 0..4
      d = rand_frame();
      d[0*IN_W +: IN_W] = IN_W'(2);
      d[1*IN_W +: IN_W] = IN_W'(3);
      d[2*IN_W +: IN_W] = IN_W'(1) << 22;
      d[3*IN_W +: IN_W] = '1;
      d[4*IN_W +: IN_W] = '0;
      step(1'b1, d, 5'd7);
      idle(14);

      // Pulse while busy, then a pulse the cycle after out_last
      step(1'b1, rand_frame(), 5'd10);
      idle(4);
      step(1'b1, rand_frame(), 5'd11);
      idle(6);
      step(1'b1, rand_frame(), 5'd12);
      idle(14);

      // Back-to-back frames with overflow cleared first
      do_reset();
      step(1'b1, rand_frame(), 5'd20);
      idle(11);
      step(1'b1, rand_frame(), 5'd21);
      idle(14);

      // Held pulse: first edge accepted, the rest dropped
      do_reset();
      step(1'b1, rand_frame(), 5'd22);
      step(1'b1, rand_frame(), 5'd23);
      step(1'b1, rand_frame(), 5'd24);
      idle(14);

      // Reset in the middle of a frame
      do_reset();
      step(1'b1, rand_frame(), 5'd25);
      idle(3);
      do_reset();
      idle(15);

      // Randomized frames, random pulse timing including drops
      m_frames = 0;
      guard    = 0;
      while (m_frames < 200 && guard < 20000) begin
         step(($urandom_range(0, 3) == 0), rand_frame(), NUM_W'($urandom));
         guard++;
      end
      chk("rand_frames", 64'(m_frames), 64'd200);
      idle(14);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_mel_log
`default_nettype wire
